// File: rtl/icache_mem_pkg.sv
// Line geometry and responder state encoding shared by the icache and its
// memory-side line responder.
package icache_mem_pkg;

  function automatic int line_bits(input int num_blocks, input int block_size);
    return 8 * block_size * num_blocks;
  endfunction

  function automatic int beats(input int num_blocks, input int block_size);
    return line_bits(num_blocks, block_size) / 32;
  endfunction

  function automatic int offset_bits(input int num_blocks);
    return $clog2(num_blocks);
  endfunction

  // Bit position of the 32-bit slice filled by a given beat.
  function automatic int beat_lsb(input int beat);
    return beat * 32;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    RESP,
    HOLD
  } resp_state_t;

endpackage

// File: rtl/imem_line_responder.sv
// Serves one icache line fill by reading BEATS consecutive 32-bit words from a
// synchronous-read backing memory and presenting the line with a ready pulse.
module imem_line_responder
  import icache_mem_pkg::*;
#(
  parameter int NUM_BLOCKS     = 4,
  parameter int BLOCK_SIZE     = 2,
  parameter int WORD_ADDR_BITS = 16,
  localparam int LINE_BITS     = line_bits(NUM_BLOCKS, BLOCK_SIZE)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      mem_req_valid,
  output logic                      mem_req_ready,
  input  logic [31:0]               mem_req_addr,
  output logic [LINE_BITS-1:0]      mem_req_rdata,
  output logic                      word_en,
  output logic [WORD_ADDR_BITS-1:0] word_addr,
  input  logic [31:0]               word_rdata
);

  localparam int BEATS       = beats(NUM_BLOCKS, BLOCK_SIZE);
  localparam int OFFSET_BITS = offset_bits(NUM_BLOCKS);
  localparam int IDX_W       = 30 - OFFSET_BITS;
  localparam int BEAT_SHIFT  = $clog2(BEATS);
  localparam int BEAT_W      = (BEATS > 1) ? BEAT_SHIFT : 1;

  if ((LINE_BITS % 32) != 0 || BEATS < 1 || (BEATS & (BEATS - 1)) != 0 ||
      (NUM_BLOCKS & (NUM_BLOCKS - 1)) != 0 || WORD_ADDR_BITS >= 32) begin : g_bad_geometry
    $error("imem_line_responder: unsupported line geometry");
  end

  resp_state_t          state_q, state_d;
  logic [BEAT_W-1:0]    beat_q;
  logic [IDX_W-1:0]     line_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic [31:0]          word_full;
  logic                 unused_bits;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_req_valid) state_d = FETCH;
      FETCH: begin
        if (!mem_req_valid)                      state_d = IDLE;
        else if (beat_q == BEAT_W'(BEATS - 1))   state_d = DRAIN;
      end
      DRAIN:   state_d = mem_req_valid ? RESP : IDLE;
      RESP:    state_d = HOLD;
      HOLD:    if (!mem_req_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each read returns one cycle late, so a FETCH cycle stores the word
  // requested by the previous beat and DRAIN stores the last one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (mem_req_valid) begin
            line_q <= mem_req_addr[31:OFFSET_BITS+2];
            beat_q <= '0;
          end
        end
        FETCH: begin
          if (mem_req_valid) begin
            if (beat_q != '0)
              rdata_q[beat_lsb(int'(beat_q) - 1) +: 32] <= word_rdata;
            if (beat_q != BEAT_W'(BEATS - 1))
              beat_q <= beat_q + 1'b1;
          end
        end
        DRAIN: begin
          if (mem_req_valid)
            rdata_q[beat_lsb(BEATS - 1) +: 32] <= word_rdata;
        end
        default: ;
      endcase
    end
  end

  // Beat count is a power of two, so the shift-or is a plain concat.
  assign word_full     = (32'(line_q) << BEAT_SHIFT) | 32'(beat_q);
  assign word_en       = (state_q == FETCH);
  assign word_addr     = word_en ? word_full[WORD_ADDR_BITS-1:0] : '0;
  assign mem_req_ready = (state_q == RESP);
  assign mem_req_rdata = rdata_q;

  assign unused_bits = ^{mem_req_addr[OFFSET_BITS+1:0], word_full[31:WORD_ADDR_BITS]};

endmodule

// File: tb/tb_imem_line_responder.sv
// Self-checking bench: default geometry plus an 8-block instance, each backed
// by a synchronous memory whose word n reads as 0xA0000000|n.
module tb_imem_line_responder;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;

  logic         v0 = 1'b0, rdy0, we0;
  logic [31:0]  a0 = '0, mrd0 = '0;
  logic [63:0]  rd0;
  logic [15:0]  wa0;

  logic         v8 = 1'b0, rdy8, we8;
  logic [31:0]  a8 = '0, mrd8 = '0;
  logic [127:0] rd8;
  logic [15:0]  wa8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_line_responder dut (
    .clk(clk), .resetn(resetn),
    .mem_req_valid(v0), .mem_req_ready(rdy0), .mem_req_addr(a0),
    .mem_req_rdata(rd0), .word_en(we0), .word_addr(wa0), .word_rdata(mrd0)
  );

  imem_line_responder #(.NUM_BLOCKS(8), .BLOCK_SIZE(2), .WORD_ADDR_BITS(16)) dut8 (
    .clk(clk), .resetn(resetn),
    .mem_req_valid(v8), .mem_req_ready(rdy8), .mem_req_addr(a8),
    .mem_req_rdata(rd8), .word_en(we8), .word_addr(wa8), .word_rdata(mrd8)
  );

  always @(posedge clk) begin
    if (we0) mrd0 <= 32'hA000_0000 | 32'(wa0);
    if (we8) mrd8 <= 32'hA000_0000 | 32'(wa8);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_valid(input bit sel);
    if (sel) v8 = 1'b0; else v0 = 1'b0;
  endtask

  // One request from the idle side; records every word read and ready pulse.
  // abort_at>0 drops valid in that cycle; otherwise valid is held hold_extra
  // cycles past the ready pulse.
  task automatic fill(input bit sel, input logic [31:0] a, input int abort_at,
                      input int hold_extra, output int lat, output int nrdy,
                      output int nwe, output logic [127:0] line,
                      output logic [7:0][15:0] wa);
    logic we, rdy;
    logic [15:0] wad;
    logic [127:0] rd;
    lat = -1; nrdy = 0; nwe = 0; line = '0; wa = '0;
    @(negedge clk);
    if (sel) begin v8 = 1'b1; a8 = a; end else begin v0 = 1'b1; a0 = a; end
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      we  = sel ? we8 : we0;
      rdy = sel ? rdy8 : rdy0;
      wad = sel ? wa8 : wa0;
      rd  = sel ? rd8 : 128'(rd0);
      if (we) begin
        if (nwe < 8) wa[nwe] = wad;
        nwe++;
      end
      if (rdy) begin
        nrdy++;
        if (lat < 0) begin lat = c; line = rd; end
      end
      if (abort_at != 0 && c == abort_at) begin drop_valid(sel); break; end
      if (lat >= 0 && c == lat + hold_extra) drop_valid(sel);
      if (lat >= 0 && c == lat + hold_extra + 2) break;
    end
    drop_valid(sel);
  endtask

  function automatic logic [15:0] ref_wa(input logic [31:0] a, input int k);
    return 16'(((a >> 4) * 2) + k);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    return {64'h0, 32'hA000_0000 | 32'(ref_wa(a, 1)), 32'hA000_0000 | 32'(ref_wa(a, 0))};
  endfunction

  typedef struct {
    string        name;
    logic [31:0]  addr;
    logic [15:0]  exp_wa0;
    logic [15:0]  exp_wa1;
    logic [63:0]  exp_line;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nrdy, nwe;
    logic [127:0] line;
    logic [7:0][15:0] wa;
    logic [31:0] ra;
    int ab;

    vecs[0] = '{"single", 32'h0000_0120, 16'h0024, 16'h0025, 64'hA000_0025_A000_0024};
    vecs[1] = '{"offset", 32'h0000_012C, 16'h0024, 16'h0025, 64'hA000_0025_A000_0024};
    vecs[2] = '{"zero",   32'h0000_0000, 16'h0000, 16'h0001, 64'hA000_0001_A000_0000};
    vecs[3] = '{"trunc",  32'hFFFF_FFF0, 16'hFFFE, 16'hFFFF, 64'hA000_FFFF_A000_FFFE};

    repeat (3) @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_word_en", we0, 0);
    chk("rst_word_addr", wa0, 0);
    chk("rst_rdata", rd0, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      fill(0, vecs[i].addr, 0, 0, lat, nrdy, nwe, line, wa);
      chk({vecs[i].name, "_lat"}, lat, 4);
      chk({vecs[i].name, "_nrdy"}, nrdy, 1);
      chk({vecs[i].name, "_nwe"}, nwe, 2);
      chk({vecs[i].name, "_wa0"}, wa[0], vecs[i].exp_wa0);
      chk({vecs[i].name, "_wa1"}, wa[1], vecs[i].exp_wa1);
      chk({vecs[i].name, "_line"}, line, 128'(vecs[i].exp_line));
    end

    // Abort in C2, then a new request raised in C3 must be accepted at once.
    fill(0, 32'h0000_0120, 2, 0, lat, nrdy, nwe, line, wa);
    chk("abort_nrdy", nrdy, 0);
    chk("abort_nwe", nwe, 2);
    fill(0, 32'h0000_0000, 0, 0, lat, nrdy, nwe, line, wa);
    chk("post_abort_lat", lat, 4);
    chk("post_abort_line", line, 128'hA000_0001_A000_0000);

    // Valid held 5 cycles past ready: one pulse, no second fetch.
    fill(0, 32'h0000_0300, 0, 5, lat, nrdy, nwe, line, wa);
    chk("sticky_nrdy", nrdy, 1);
    chk("sticky_nwe", nwe, 2);
    chk("sticky_line", line, ref_line(32'h0000_0300));
    fill(0, 32'h0000_0310, 0, 0, lat, nrdy, nwe, line, wa);
    chk("sticky_next_lat", lat, 4);
    chk("sticky_next_line", line, ref_line(32'h0000_0310));

    // Asynchronous reset in the middle of a FETCH cycle.
    @(negedge clk);
    v0 = 1'b1; a0 = 32'h0000_0120;
    @(negedge clk);
    chk("arst_pre_we", we0, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_word_en", we0, 0);
    chk("arst_word_addr", wa0, 0);
    chk("arst_ready", rdy0, 0);
    chk("arst_rdata", rd0, 0);
    v0 = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    fill(0, 32'h0000_0120, 0, 0, lat, nrdy, nwe, line, wa);
    chk("arst_after_lat", lat, 4);
    chk("arst_after_line", line, 128'hA000_0025_A000_0024);

    // Randomized requests with random aborts against the address/data model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      ab = $urandom_range(0, 5);
      if (ab > 3) ab = 0;
      fill(0, ra, ab, $urandom_range(0, 2), lat, nrdy, nwe, line, wa);
      if (ab != 0) begin
        chk("rand_abort_nrdy", nrdy, 0);
        chk("rand_abort_nwe", nwe, (ab < 2) ? ab : 2);
      end else begin
        chk("rand_lat", lat, 4);
        chk("rand_nrdy", nrdy, 1);
        chk("rand_wa0", wa[0], ref_wa(ra, 0));
        chk("rand_wa1", wa[1], ref_wa(ra, 1));
        chk("rand_line", line, ref_line(ra));
      end
    end

    // Eight-block geometry: four beats, line index 2.
    fill(1, 32'h0000_0040, 0, 0, lat, nrdy, nwe, line, wa);
    chk("geo_lat", lat, 6);
    chk("geo_nrdy", nrdy, 1);
    chk("geo_nwe", nwe, 4);
    for (int k = 0; k < 4; k++) chk("geo_wa", wa[k], 16'(8 + k));
    chk("geo_line", line, 128'hA000_000B_A000_000A_A000_0009_A000_0008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
